// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: FSM encoding, NOP word, default
// address-map constants and a saturating increment for the performance counters.
package fetch_sequencer_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR         = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TEXT_BASE = 32'h0040_0000;
    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0040_0000;

    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == '1) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/fetch_sequencer_if_id.sv
// IF/ID pipeline register: flush and nop_load force a NOP (valid=0) and
// override stall; stall alone holds the contents.
module if_id_register
    import fetch_sequencer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  nop_load,
    input  logic [DATA_WIDTH-1:0] instr_in,
    input  logic [DATA_WIDTH-1:0] pc_plus4_in,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] pc_plus4,
    output logic                  valid
);

    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [DATA_WIDTH-1:0] pc_plus4_q, pc_plus4_d;
    logic                  valid_q, valid_d;

    always_comb begin
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        if (flush || nop_load) begin
            instr_d    = DATA_WIDTH'(NOP_INSTR);
            pc_plus4_d = '0;
            valid_d    = 1'b0;
        end else if (!stall) begin
            instr_d    = instr_in;
            pc_plus4_d = pc_plus4_in;
            valid_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q    <= '0;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign instr    = instr_q;
    assign pc_plus4 = pc_plus4_q;
    assign valid    = valid_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: PC register, RUN/HALT FSM, fetch-fault detection
// and IF/ID register. Optional perf counters under FETCH_SEQUENCER_PERF_EN.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int unsigned                  DATA_WIDTH   = 32,
    parameter int unsigned                  MEMORY_DEPTH = 256,
    parameter logic [DATA_WIDTH-1:0]        TEXT_BASE    = DATA_WIDTH'(DEFAULT_TEXT_BASE),
    parameter logic [DATA_WIDTH-1:0]        RESET_PC     = DATA_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  redirect,
    input  logic [DATA_WIDTH-1:0] redirect_target,
    input  logic                  halt_req,
    output logic [DATA_WIDTH-1:0] mem_address,
    input  logic [DATA_WIDTH-1:0] mem_instruction,
    output logic [DATA_WIDTH-1:0] if_instr,
    output logic [DATA_WIDTH-1:0] if_pc_plus4,
    output logic                  if_valid,
    output logic [DATA_WIDTH-1:0] pc,
    output logic                  halted,
    output logic                  fault,
    output logic [31:0]           fetch_count,
    output logic [31:0]           stall_count
);

    // One extra bit so the end of the text window cannot wrap.
    localparam logic [DATA_WIDTH:0] TEXT_END =
        {1'b0, TEXT_BASE} + (DATA_WIDTH + 1)'(4 * MEMORY_DEPTH);

    fetch_state_e          state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic                  fault_q, fault_d;
    logic [DATA_WIDTH-1:0] pc_plus4;
    logic                  fetch_fault;
    logic                  run;
    logic                  ifid_flush;
    logic                  ifid_nop;

    assign pc_plus4    = pc_q + DATA_WIDTH'(4);
    assign fetch_fault = (pc_q < TEXT_BASE) || ({1'b0, pc_q} >= TEXT_END) || (pc_q[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (halt_req || fetch_fault) state_d = HALT;
            default: state_d = HALT;
        endcase
    end

    always_comb begin
        run    = (state_q == RUN);
        halted = (state_q == HALT);
    end

    // A faulting PC is retained; halt_req alone still lets the PC advance/redirect.
    always_comb begin
        pc_d    = pc_q;
        fault_d = fault_q;
        if (run) begin
            if (fetch_fault) begin
                fault_d = 1'b1;
            end else if (redirect) begin
                pc_d = redirect_target;
            end else if (!stall) begin
                pc_d = pc_plus4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        ifid_flush = flush || redirect;
        ifid_nop   = !run || fetch_fault || halt_req;
    end

    if_id_register #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_if_id (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .flush       (ifid_flush),
        .nop_load    (ifid_nop),
        .instr_in    (mem_instruction),
        .pc_plus4_in (pc_plus4),
        .instr       (if_instr),
        .pc_plus4    (if_pc_plus4),
        .valid       (if_valid)
    );

`ifdef FETCH_SEQUENCER_PERF_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] stall_count_q, stall_count_d;
    logic        fetch_fire;

    always_comb begin
        fetch_fire    = run && !stall && !ifid_flush && !ifid_nop;
        fetch_count_d = fetch_fire ? sat_inc32(fetch_count_q) : fetch_count_q;
        stall_count_d = (run && stall) ? sat_inc32(stall_count_q) : stall_count_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
    assign stall_count = stall_count_q;
`else
    assign fetch_count = '0;
    assign stall_count = '0;
`endif

    assign mem_address = pc_q - TEXT_BASE;
    assign pc          = pc_q;
    assign fault       = fault_q;

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the width of the PC, instruction and address paths.
REQ-002 Parameter MEMORY_DEPTH, default 256, SHALL set the program memory depth in words.
REQ-003 Parameter TEXT_BASE, default 32'h0040_0000, SHALL set the byte address that maps to program memory word 0.
REQ-004 Parameter RESET_PC, default 32'h0040_0000, SHALL set the PC loaded on reset.
REQ-005 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 reset  input  1  SHALL be the reset: synchronous, active-high.
REQ-007 stall  input  1  SHALL hold the PC and the IF/ID register (hazard unit).
REQ-008 flush  input  1  SHALL invalidate the IF/ID register on the next edge.
REQ-009 redirect  input  1  SHALL request a PC load from redirect_target (branch/jump taken).
REQ-010 redirect_target  input  DATA_WIDTH  SHALL carry the branch/jump target byte address.
REQ-011 halt_req  input  1  SHALL request an orderly stop of fetching.
REQ-012 mem_address  output  DATA_WIDTH  SHALL drive the program memory Address port: combinational PC - TEXT_BASE.
REQ-013 mem_instruction  input  DATA_WIDTH  SHALL receive the combinational program memory Instruction.
REQ-014 if_instr  output  DATA_WIDTH  SHALL be the registered IF/ID instruction.
REQ-015 if_pc_plus4  output  DATA_WIDTH  SHALL be the registered PC+4 of if_instr.
REQ-016 if_valid  output  1  SHALL mark if_instr as a real instruction.
REQ-017 pc  output  DATA_WIDTH  SHALL expose the current PC register.
REQ-018 halted  output  1  SHALL be high in state HALT.
REQ-019 fault  output  1  SHALL be a sticky fetch-fault flag.
REQ-020 fetch_count, stall_count  output  32 each  SHALL be performance counters (see Configuration).

Function
REQ-021 FSM states SHALL be RUN and HALT; RUN -> HALT on halt_req or a fault; HALT exits only by reset.
REQ-022 In RUN, PC next-value priority SHALL be: redirect (PC <= redirect_target) > stall (hold) > PC <= PC+4, modulo 2^DATA_WIDTH.
REQ-023 IF/ID SHALL capture {mem_instruction, PC+4, valid=1} each RUN edge with no stall, so if_instr reflects the PC one cycle after that PC is presented.
REQ-024 flush or redirect SHALL load IF/ID with instr=0 (NOP), valid=0, even if stall is asserted in the same cycle.
REQ-025 stall without flush/redirect SHALL hold the IF/ID contents unchanged.
REQ-026 A fault SHALL occur when the PC about to be fetched is < TEXT_BASE, is >= TEXT_BASE+4*MEMORY_DEPTH, or has PC[1:0] != 0; the offending PC SHALL be retained in pc.
REQ-027 On fault: fault <= 1, state <= HALT, IF/ID <= NOP/valid=0 on the same edge.
REQ-028 A redirect to a faulting target SHALL load the PC and raise the fault one cycle later, when that PC is fetched.
REQ-029 halt_req together with redirect SHALL take halt; the PC still loads the redirect target.
REQ-030 In HALT: PC frozen, if_valid=0, if_instr=0, and stall/flush/redirect ignored.

Reset
REQ-031 On reset: PC=RESET_PC, state=RUN, if_instr=0, if_pc_plus4=0, if_valid=0, fault=0, halted=0, counters=0.
REQ-032 reset SHALL override every other input in the same cycle, including mid-stall and mid-redirect.

Configuration
REQ-033 Macro FETCH_SEQUENCER_PERF_EN defined: fetch_count SHALL increment on each valid IF/ID capture and stall_count on each RUN cycle with stall=1; both SHALL saturate at 32'hFFFF_FFFF.
REQ-034 Macro undefined: both counters SHALL be tied to 0 and no counter flops SHALL be synthesized; the port list is unchanged.

Structure
REQ-035 A shared package SHALL hold the FSM state encoding (RUN=0, HALT=1), the NOP constant 32'h0000_0000 and the default TEXT_BASE/RESET_PC constants.
REQ-036 The IF/ID register SHALL be a sub-module named if_id_register with stall, flush and NOP-load inputs.

Verification
REQ-037 Release reset, no stall, ROM word0=32'h2008_0005: cycle 1 mem_address=0; cycle 2 if_instr=32'h2008_0005, if_pc_plus4=32'h0040_0004, if_valid=1.
REQ-038 stall high 3 cycles at PC=32'h0040_0008 -> pc and if_instr constant for 3 cycles; stall_count +3 with the macro, 0 without.
REQ-039 redirect=1, redirect_target=32'h0040_0020, stall=1 in the same cycle -> next pc=32'h0040_0020 and if_valid=0; the following cycle if_instr=ROM word 8.
REQ-040 redirect_target=32'h0040_0402 -> pc=32'h0040_0402, next edge fault=1, halted=1, if_valid=0; PC frozen until reset.
REQ-041 halt_req pulse at PC=32'h0040_0010 -> halted=1 thereafter, fault=0; reset then returns pc=32'h0040_0000, state RUN.
REQ-042 Force fetch_count to 32'hFFFF_FFFE (macro on), run 3 fetches -> fetch_count stays at 32'hFFFF_FFFF.
